// File: rtl/wb_commit_queue_pkg.sv
// Shared widths, control encodings and the commit record layout for the
// writeback retirement queue.
package wb_commit_queue_pkg;

  localparam int REG_W      = 64;
  localparam int REG_ADDR_W = 5;
  localparam int CSR_ADDR_W = 12;
  localparam int ADDR_W     = 64;
  localparam int CTRL_W     = 6;

  // Control value meaning "MEM/WB holds its contents this cycle".
  localparam logic [CTRL_W-1:0] CTRL_STATE_BLOCK   = 6'b000011;
  localparam logic [ADDR_W-1:0] INVALID_PC_DEFAULT = 64'h0;

  typedef struct packed {
    logic [ADDR_W-1:0]     pc;
    logic                  rd_wen;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [REG_W-1:0]      rd_data;
    logic                  csr_wen;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [REG_W-1:0]      csr_data;
  } commit_rec_t;

  localparam int COMMIT_REC_W = $bits(commit_rec_t);

endpackage

// File: rtl/wb_commit_queue_fifo.sv
// Synchronous FIFO holding commit records. A push is accepted when not full,
// or when full and a pop happens in the same cycle; pop_i is ignored when empty.
module commit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == (AW+1)'(DEPTH));
    count_o = count_q;
    rdata_o = mem_q[head_q];
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[tail_q] = wdata_i;
      tail_d        = tail_q + AW'(1);
    end
    if (do_pop) head_d = head_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through a nonzero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_commit_queue.sv
// Turns each freshly loaded WB-stage instruction into one commit record and
// offers the records over a valid/ready port (valid independent of ready).
module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] INVALID_PC = INVALID_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     wb_pc_i,
  input  logic                  wb_wreg_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
  input  logic [REG_W-1:0]      wb_wdata_i,
  input  logic                  wb_csr_wreg_i,
  input  logic [CSR_ADDR_W-1:0] wb_csr_waddr_i,
  input  logic [REG_W-1:0]      wb_csr_wdata_i,
  input  logic [CTRL_W-1:0]     ctrl_signal_i,
  output logic                  commit_valid_o,
  input  logic                  commit_ready_i,
  output logic [ADDR_W-1:0]     commit_pc_o,
  output logic                  commit_rd_wen_o,
  output logic [REG_ADDR_W-1:0] commit_rd_addr_o,
  output logic [REG_W-1:0]      commit_rd_data_o,
  output logic                  commit_csr_wen_o,
  output logic [CSR_ADDR_W-1:0] commit_csr_addr_o,
  output logic [REG_W-1:0]      commit_csr_data_o,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic [63:0]           retired_o
);

  localparam int AW = $clog2(DEPTH);

  logic              wb_new_q, wb_new_d;
  logic              overflow_q, overflow_d;
  logic [63:0]       retired_q, retired_d;
  logic              push, pop, fifo_full, fifo_empty;
  logic [AW:0]       fifo_count;
  logic [COMMIT_REC_W-1:0] head_bits;
  commit_rec_t       push_rec, head_rec, out_rec;

  always_comb begin
    // A non-Block control this cycle means MEM/WB reloads on the next edge.
    wb_new_d                = (ctrl_signal_i != CTRL_STATE_BLOCK);
    push                    = wb_new_q && (wb_pc_i != INVALID_PC);
    commit_valid_o          = !fifo_empty;
    pop                     = commit_valid_o && commit_ready_i;
    push_rec.pc             = wb_pc_i;
    push_rec.rd_wen         = wb_wreg_i && (wb_rd_addr_i != '0);
    push_rec.rd_addr        = wb_rd_addr_i;
    push_rec.rd_data        = wb_wdata_i;
    push_rec.csr_wen        = wb_csr_wreg_i;
    push_rec.csr_addr       = wb_csr_waddr_i;
    push_rec.csr_data       = wb_csr_wdata_i;
    overflow_d              = overflow_q || (push && fifo_full && !pop);
    retired_d               = retired_q + ((push && (!fifo_full || pop)) ? 64'd1 : 64'd0);
    head_rec                = head_bits;
    out_rec                 = commit_valid_o ? head_rec : '0;
    commit_pc_o             = out_rec.pc;
    commit_rd_wen_o         = out_rec.rd_wen;
    commit_rd_addr_o        = out_rec.rd_addr;
    commit_rd_data_o        = out_rec.rd_data;
    commit_csr_wen_o        = out_rec.csr_wen;
    commit_csr_addr_o       = out_rec.csr_addr;
    commit_csr_data_o       = out_rec.csr_data;
    full_o                  = fifo_count[AW];
    overflow_o              = overflow_q;
    retired_o               = retired_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_new_q   <= 1'b0;
      overflow_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      wb_new_q   <= wb_new_d;
      overflow_q <= overflow_d;
      retired_q  <= retired_d;
    end
  end

  commit_fifo #(
    .WIDTH (COMMIT_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_rec),
    .rdata_o (head_bits),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
